top_countdown_timer: RTL and testbench
======================================

# top_countdown_timer

Countdown companion to the stopwatch: it loads a minutes/seconds preset, counts down to 00:00.00 in centisecond steps on the divided clock `new_clk`, and raises `done` at zero. Start/stop uses the same single-button toggle as the stopwatch. The six digits drive the board's seven-segment displays as three mm/ss/cc pairs.

## Interface
- `TICK_DIV`, default 10: `new_clk` cycles per centisecond. 1 kHz `new_clk` gives 100 Hz.
- `BLINK_TICKS`, default 25: centisecond ticks per half-period of the done blink.
- `rst` input 1: asynchronous, active-low reset.
- `new_clk` input 1: divided system clock; all state is on its rising edge.
- `start_stop` input 1: raw start/stop button, level, asynchronous to `new_clk`.
- `load` input 1: raw preset-load button, level, asynchronous.
- `set_min` input 7: preset minutes, quasi-static switches, binary.
- `set_sec` input 7: preset seconds, quasi-static switches, binary.
- `h10`, `h1` output 7: minutes tens/units, active-low segments {g,f,e,d,c,b,a}.
- `m10`, `m1` output 7: seconds tens/units.
- `s10`, `s1` output 7: centiseconds tens/units.
- `running` output 1: high in RUN.
- `done` output 1: high in DONE.

## Operation
- Synchronizers: each of `start_stop` and `load` passes through two flops (meta, sync) plus a prev flop. Edge = sync & ~prev.
- Count registers: `min` 0–59, `sec` 0–59, `cs` 0–99, all binary. A 7-bit prescaler runs 0..TICK_DIV-1.
- States:
  - IDLE: load edge → min=clamp(set_min), sec=clamp(set_sec), cs=0, prescaler=0; stay IDLE. Start edge with nonzero count → RUN. Start edge with zero count → ignored.
  - RUN: prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and the count decrements by one centisecond. cs 0→99 borrows from sec; sec 0→59 borrows from min. Start edge → PAUSE. Load edges are ignored.
  - PAUSE: prescaler and count hold. Start edge → RUN, resuming the prescaler from its held value. Load edge → reload as in IDLE, then IDLE.
  - DONE: count holds at 0. Start edge → IDLE (acknowledge). Load edge → reload, then IDLE.
- Clamp: any value >59 loads as 59.
- Zero detection: the decrement that produces 00:00.00 moves the state to DONE on the same edge. The count never wraps below zero.
- Simultaneous start and load edges:
  - In RUN, start wins.
  - In every other state, load wins and the start edge is discarded.
- Display: each count value is split into tens = v/10 and units = v%10 and encoded active-low. The digit 0 is 7'b1000000.

## Timing
- Reset (async assert, release synchronous to `new_clk`):
  - State IDLE; min, sec, cs, prescaler and blink counters all 0; synchronizer flops 0.
  - `running`=0, `done`=0.
  - All six digit outputs = 7'b1000000 (display "00 00 00").
- Button latency: an input rising before edge N is first visible as an edge at edge N+2. The state, count and `running`/`done` registers update at edge N+2.
- Decrement rate: in RUN, exactly one centisecond decrement per TICK_DIV cycles. The first decrement lands TICK_DIV cycles after entry to RUN from a fresh load.
- `done` rises on the same edge as the final decrement; `running` falls on that edge.
- Digit outputs are combinational from the count registers. A display change is visible in the same cycle as the count change.
- Reset asserted mid-RUN returns immediately to the reset values; the preset is lost.

## Configuration
- `TIMER_ALARM_BLINK_EN` defined:
  - In DONE, a blink counter advances on prescaler wraps.
  - All six digits alternate between "0" and blank (7'h7F), toggling every BLINK_TICKS centiseconds and starting with blank on DONE entry.
  - `done` stays steady high.
- `TIMER_ALARM_BLINK_EN` undefined: no blink counter; DONE shows a steady "00 00 00".

## Structure
- Shared package `timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - constants MAX_MIN=59, MAX_SEC=59, MAX_CS=99;
  - the digit-0 and blank segment codes;
  - the 0–9 segment lookup.
- One sub-module, `timer_seg7_pair`: 7-bit binary value plus a blank input in, tens and units segment codes out. It is instantiated three times.

## Test plan
- Reset: hold rst=0 → all digits 7'b1000000, `running`=0, `done`=0, state IDLE.
- Load clamp: set_min=75, set_sec=30, pulse load → display "59 30 00", state IDLE.
- Countdown with borrow: load 0:01, start, TICK_DIV=10 → after 10 cycles "00 00 99"; after 1000 cycles `done`=1 on the final-decrement edge, `running`=0.
- Pause and resume: run from 1:00 for 50 ticks, press start → count frozen at "00 59 50" for 200 cycles; press start again → resumes with no lost or extra tick.
- Simultaneous events: same-cycle edges in PAUSE → reload and IDLE; in RUN → PAUSE with the count unchanged. Start edge in IDLE at zero → ignored.
- Reset mid-run: assert rst during RUN at "00 42 17" → immediate "00 00 00", IDLE. With `TIMER_ALARM_BLINK_EN`: DONE display blank for 250 cycles, then "0" for 250 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM states, count limits,
// and the active-low seven-segment codes {g,f,e,d,c,b,a}.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] MAX_MIN = 7'd59;
  localparam logic [6:0] MAX_SEC = 7'd59;
  localparam logic [6:0] MAX_CS  = 7'd99;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_ZERO;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] clamp(input logic [6:0] value, input logic [6:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/timer_seg7_pair.sv
// Splits a 0..99 binary value into tens/units and drives two active-low digits;
// blank forces both digits dark.
module timer_seg7_pair
  import timer_pkg::*;
(
  input  logic [6:0] value,
  input  logic       blank,
  output logic [6:0] tens,
  output logic [6:0] units
);

  always_comb begin
    tens  = blank ? SEG_BLANK : seg7(4'(value / 7'd10));
    units = blank ? SEG_BLANK : seg7(4'(value % 7'd10));
  end

endmodule

// File: rtl/top_countdown_timer.sv
// Countdown timer: loads an mm:ss preset, counts down in centiseconds on new_clk,
// raises done at 00:00.00. Define TIMER_ALARM_BLINK_EN to blink the digits in DONE.
//
// state | meaning
// IDLE  | preset loaded or cleared, waiting for start
// RUN   | prescaler running, one centisecond off per TICK_DIV cycles
// PAUSE | prescaler and count frozen
// DONE  | reached zero, waiting for start (ack) or load
module top_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV    = 10,
  parameter int BLINK_TICKS = 25
) (
  input  logic       rst,
  input  logic       new_clk,
  input  logic       start_stop,
  input  logic       load,
  input  logic [6:0] set_min,
  input  logic [6:0] set_sec,
  output logic [6:0] h10,
  output logic [6:0] h1,
  output logic [6:0] m10,
  output logic [6:0] m1,
  output logic [6:0] s10,
  output logic [6:0] s1,
  output logic       running,
  output logic       done
);

  if (TICK_DIV < 1 || TICK_DIV > 128 || BLINK_TICKS < 1 || BLINK_TICKS > 256) begin : g_param_check
    $error("top_countdown_timer: TICK_DIV must be 1..128 and BLINK_TICKS 1..256");
  end

  logic   ss_meta, ss_sync, ss_prev;
  logic   ld_meta, ld_sync, ld_prev;
  logic   start_edge, load_edge;
  state_t state;
  logic [6:0] min_r, sec_r, cs_r, presc;
  logic   tick, count_zero, last_cs, reload, blank;
`ifdef TIMER_ALARM_BLINK_EN
  logic [7:0] blink_cnt;
  logic       blink_on;
`endif

  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      ss_meta <= 1'b0;
      ss_sync <= 1'b0;
      ss_prev <= 1'b0;
      ld_meta <= 1'b0;
      ld_sync <= 1'b0;
      ld_prev <= 1'b0;
    end else begin
      ss_meta <= start_stop;
      ss_sync <= ss_meta;
      ss_prev <= ss_sync;
      ld_meta <= load;
      ld_sync <= ld_meta;
      ld_prev <= ld_sync;
    end
  end

  assign start_edge = ss_sync & ~ss_prev;
  assign load_edge  = ld_sync & ~ld_prev;
  assign tick       = (presc == 7'(TICK_DIV - 1));
  assign count_zero = (min_r == 7'd0) && (sec_r == 7'd0) && (cs_r == 7'd0);
  assign last_cs    = (min_r == 7'd0) && (sec_r == 7'd0) && (cs_r == 7'd1);
  // Load beats start everywhere except RUN, where load is ignored outright.
  assign reload     = load_edge && (state != RUN);

  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      min_r   <= 7'd0;
      sec_r   <= 7'd0;
      cs_r    <= 7'd0;
      presc   <= 7'd0;
      running <= 1'b0;
      done    <= 1'b0;
`ifdef TIMER_ALARM_BLINK_EN
      blink_cnt <= 8'd0;
      blink_on  <= 1'b0;
`endif
    end else if (reload) begin
      state   <= IDLE;
      min_r   <= clamp(set_min, MAX_MIN);
      sec_r   <= clamp(set_sec, MAX_SEC);
      cs_r    <= 7'd0;
      presc   <= 7'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge && !count_zero) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (start_edge) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            presc <= 7'd0;
            if (cs_r != 7'd0) begin
              cs_r <= cs_r - 7'd1;
            end else begin
              cs_r <= MAX_CS;
              if (sec_r != 7'd0) begin
                sec_r <= sec_r - 7'd1;
              end else begin
                sec_r <= MAX_SEC;
                min_r <= min_r - 7'd1;
              end
            end
            if (last_cs) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
`ifdef TIMER_ALARM_BLINK_EN
              blink_cnt <= 8'd0;
              blink_on  <= 1'b0;
`endif
            end
          end else begin
            presc <= presc + 7'd1;
          end
        end
        PAUSE: begin
          if (start_edge) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          if (start_edge) begin
            state <= IDLE;
            done  <= 1'b0;
            presc <= 7'd0;
          end
`ifdef TIMER_ALARM_BLINK_EN
          else if (tick) begin
            presc <= 7'd0;
            if (blink_cnt == 8'(BLINK_TICKS - 1)) begin
              blink_cnt <= 8'd0;
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt + 8'd1;
            end
          end else begin
            presc <= presc + 7'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TIMER_ALARM_BLINK_EN
  assign blank = (state == DONE) && !blink_on;
`else
  assign blank = 1'b0;
`endif

  timer_seg7_pair u_min (.value(min_r), .blank(blank), .tens(h10), .units(h1));
  timer_seg7_pair u_sec (.value(sec_r), .blank(blank), .tens(m10), .units(m1));
  timer_seg7_pair u_cs  (.value(cs_r),  .blank(blank), .tens(s10), .units(s1));

endmodule

// File: tb/tb_top_countdown_timer.sv
// Bench for top_countdown_timer: load-clamp vector table, directed corner sequences
// and randomized button activity against a total-centisecond reference model.
module tb_top_countdown_timer;

  localparam int TICK_DIV    = 10;
  localparam int BLINK_TICKS = 25;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       rst, new_clk, start_stop, load;
  logic [6:0] set_min, set_sec;
  logic [6:0] h10, h1, m10, m1, s10, s1;
  logic       running, done;
  logic [41:0] dut_disp;

  top_countdown_timer #(.TICK_DIV(TICK_DIV), .BLINK_TICKS(BLINK_TICKS)) dut (
    .rst(rst), .new_clk(new_clk), .start_stop(start_stop), .load(load),
    .set_min(set_min), .set_sec(set_sec),
    .h10(h10), .h1(h1), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .running(running), .done(done)
  );

  assign dut_disp = {h10, h1, m10, m1, s10, s1};

  initial new_clk = 1'b0;
  always #5 new_clk = ~new_clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: whole count as centiseconds, run-cycle phase, button histories.
  int m_mode, m_tot, m_ph, m_done_cyc;
  bit hs[$];
  bit hl[$];

  function automatic logic [6:0] seg(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] disp(int mi, int se, int cs);
    return {seg(mi / 10), seg(mi % 10), seg(se / 10), seg(se % 10), seg(cs / 10), seg(cs % 10)};
  endfunction

  function automatic int clamp59(int v);
    return (v > 59) ? 59 : v;
  endfunction

  function automatic logic [41:0] model_disp();
`ifdef TIMER_ALARM_BLINK_EN
    if (m_mode == M_DONE && ((m_done_cyc / (TICK_DIV * BLINK_TICKS)) % 2 == 0))
      return {6{7'h7F}};
`endif
    return disp(m_tot / 6000, (m_tot / 100) % 60, m_tot % 100);
  endfunction

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_tot = 0; m_ph = 0; m_done_cyc = 0;
    hs = '{0, 0, 0, 0};
    hl = '{0, 0, 0, 0};
  endtask

  task automatic model_edge();
    bit se, le;
    hs.push_back(start_stop); void'(hs.pop_front());
    hl.push_back(load);       void'(hl.pop_front());
    // An input level sampled at edge j is seen as an edge at j+2.
    se = hs[1] && !hs[0];
    le = hl[1] && !hl[0];
    if (le && m_mode != M_RUN) begin
      m_tot  = clamp59(int'(set_min)) * 6000 + clamp59(int'(set_sec)) * 100;
      m_ph   = 0;
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:  if (se && m_tot > 0) m_mode = M_RUN;
        M_RUN: begin
          if (se) m_mode = M_PAUSE;
          else begin
            m_ph++;
            if (m_ph == TICK_DIV) begin
              m_ph = 0;
              m_tot--;
              if (m_tot == 0) begin
                m_mode = M_DONE;
                m_done_cyc = 0;
              end
            end
          end
        end
        M_PAUSE: if (se) m_mode = M_RUN;
        default: begin
          if (se) begin
            m_mode = M_IDLE;
            m_ph = 0;
          end else m_done_cyc++;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge new_clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    check("model", {dut_disp, running, done},
          {model_disp(), 1'(m_mode == M_RUN), 1'(m_mode == M_DONE)});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input int mi, input int se);
    set_min = 7'(mi); set_sec = 7'(se);
    load = 1'b1; tick();
    load = 1'b0; ticks(3);
  endtask

  task automatic press_start();
    start_stop = 1'b1; tick();
    start_stop = 1'b0; tick();
  endtask

  task automatic wait_running(input int max_cyc);
    int k = 0;
    while (!running && k < max_cyc) begin
      tick();
      k++;
    end
    check("wait_running", 44'(running), 44'(1));
  endtask

  typedef struct {
    int mi, se;
    int exp_m, exp_s;
  } load_vec_t;
  load_vec_t lv[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lv[0] = '{75, 30, 59, 30};
    lv[1] = '{0, 1, 0, 1};
    lv[2] = '{59, 59, 59, 59};
    lv[3] = '{60, 127, 59, 59};
    lv[4] = '{12, 0, 12, 0};

    rst = 1'b0; start_stop = 1'b0; load = 1'b0; set_min = 7'd0; set_sec = 7'd0;
    model_reset();
    #2;
    check("reset_disp", 44'(dut_disp), 44'(disp(0, 0, 0)));
    check("reset_flags", 44'({running, done}), 44'(2'b00));
    ticks(3);
    rst = 1'b1;
    ticks(2);

    for (int i = 0; i < 5; i++) begin
      do_load(lv[i].mi, lv[i].se);
      check("load_clamp", 44'(dut_disp), 44'(disp(lv[i].exp_m, lv[i].exp_s, 0)));
      check("load_idle", 44'({running, done}), 44'(2'b00));
    end

    // 0:01 countdown, borrow into cs, done on final decrement
    do_load(0, 1);
    start_stop = 1'b1; tick(); start_stop = 1'b0;
    wait_running(10);
    ticks(10);
    check("borrow_99", 44'(dut_disp), 44'(disp(0, 0, 99)));
    ticks(989);
    check("before_final", 44'({dut_disp, running, done}), {disp(0, 0, 1), 2'b10});
    tick();
    check("final_edge", 44'({dut_disp, running, done}), {disp(0, 0, 0), 2'b01});
`ifdef TIMER_ALARM_BLINK_EN
    ticks(249);
    check("blink_blank", 44'({dut_disp, done}), 44'({{6{7'h7F}}, 1'b1}));
    tick();
    check("blink_zero", 44'({dut_disp, done}), 44'({disp(0, 0, 0), 1'b1}));
    ticks(249);
    check("blink_zero_end", 44'(dut_disp), 44'(disp(0, 0, 0)));
    tick();
    check("blink_blank2", 44'(dut_disp), 44'({6{7'h7F}}));
`else
    ticks(250);
    check("done_steady", 44'({dut_disp, running, done}), {disp(0, 0, 0), 2'b01});
`endif
    press_start();
    ticks(2);
    check("done_ack", 44'({running, done}), 44'(2'b00));

    // start at zero count is ignored
    press_start();
    ticks(20);
    check("idle_zero_start", 44'({dut_disp, running, done}), {disp(0, 0, 0), 2'b00});

    // pause and resume from 1:00
    do_load(1, 0);
    start_stop = 1'b1; tick(); start_stop = 1'b0;
    wait_running(10);
    ticks(500);
    check("run_50_ticks", 44'(dut_disp), 44'(disp(0, 59, 50)));
    press_start();
    tick();
    check("paused", 44'({running, done}), 44'(2'b00));
    ticks(200);
    check("pause_frozen", 44'(dut_disp), 44'(disp(0, 59, 50)));
    press_start();
    tick();
    check("resumed", 44'(running), 44'(1));
    ticks(7);
    check("resume_no_extra", 44'(dut_disp), 44'(disp(0, 59, 50)));
    tick();
    check("resume_no_lost", 44'(dut_disp), 44'(disp(0, 59, 49)));

    // simultaneous edges in RUN: start wins, load ignored
    ticks(5);
    set_min = 7'd3; set_sec = 7'd4;
    start_stop = 1'b1; load = 1'b1; tick();
    start_stop = 1'b0; load = 1'b0; tick(); tick();
    check("run_both", 44'({dut_disp, running, done}), {disp(0, 59, 49), 2'b00});
    ticks(30);
    check("run_both_hold", 44'(dut_disp), 44'(disp(0, 59, 49)));

    // simultaneous edges in PAUSE: load wins, back to IDLE
    start_stop = 1'b1; load = 1'b1; tick();
    start_stop = 1'b0; load = 1'b0; tick(); tick();
    check("pause_both", 44'({dut_disp, running, done}), {disp(3, 4, 0), 2'b00});
    ticks(30);
    check("pause_both_idle", 44'({dut_disp, running}), 44'({disp(3, 4, 0), 1'b0}));

    // reset mid-run
    do_load(0, 43);
    start_stop = 1'b1; tick(); start_stop = 1'b0;
    wait_running(10);
    ticks(830);
    check("pre_reset", 44'(dut_disp), 44'(disp(0, 42, 17)));
    #3 rst = 1'b0;
    model_reset();
    #1;
    check("async_reset", 44'({dut_disp, running, done}), {disp(0, 0, 0), 2'b00});
    ticks(2);
    rst = 1'b1;
    ticks(3);
    press_start();
    ticks(20);
    check("preset_lost", 44'({dut_disp, running}), 44'({disp(0, 0, 0), 1'b0}));

    // randomized buttons and presets
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 39) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 59) == 0) begin
        load = ~load;
        set_min = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
        set_sec = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 2));
      end
      tick();
    end
    start_stop = 1'b0; load = 1'b0;
    ticks(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
